module_gray_input_filter: RTL



---
 rtl/module_gray_input_filter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/module_gray_input_filter.sv
// Gray input conditioning stage for the Gray decoder path.
//
// Brings the raw Gray code from the board switches into the clk_i domain, samples
// it at a slow prescaled rate and only accepts a new code after it has been seen
// on STABLE_COUNT consecutive sample ticks. An accepted code is published as its
// registered binary equivalent together with a one-cycle change strobe.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   codigo_gray_i  raw Gray code from the switches (asynchronous to clk_i)
//   codigo_bin_o   binary value of the last accepted Gray code (registered)
//   cambio_o       one-cycle pulse when codigo_bin_o takes a new value
module module_gray_input_filter #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SAMPLE_PERIOD = 2700000,
  parameter int unsigned STABLE_COUNT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] codigo_gray_i,
  output logic [WIDTH-1:0] codigo_bin_o,
  output logic             cambio_o
);

  localparam int unsigned PreW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned CntW = $clog2(STABLE_COUNT + 1);

  localparam logic [PreW-1:0] PreLast    = PreW'(SAMPLE_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntAccept  = CntW'(STABLE_COUNT);

  typedef enum logic [0:0] {
    StEstable,
    StValidando
  } state_e;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // Two-flop synchroniser per bit; sync_q is the value seen by the filter.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= codigo_gray_i;
      sync_q <= meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running prescaler. It is never restarted by input activity, so the
  // sample grid depends only on time since reset release.
  // --------------------------------------------------------------------------
  logic [PreW-1:0] pre_q;
  logic            tick;

  assign tick = (pre_q == PreLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PreW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter. Only acts on tick cycles; every register holds otherwise.
  // --------------------------------------------------------------------------
  state_e           state_q;
  logic [WIDTH-1:0] acc_q;   // last accepted Gray code
  logic [WIDTH-1:0] cand_q;  // code currently being validated
  logic [CntW-1:0]  cnt_q;   // consecutive ticks that have seen cand_q
  logic [CntW-1:0]  cnt_inc;

  // cnt_q never exceeds STABLE_COUNT-1, so the increment always fits.
  assign cnt_inc = cnt_q + CntOne;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StEstable;
      acc_q        <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      codigo_bin_o <= '0;
      cambio_o     <= 1'b0;
    end else begin
      // Strobe defaults low; only an accepting tick raises it for one cycle.
      cambio_o <= 1'b0;
      if (tick) begin
        case (state_q)
          StEstable: begin
            if (sync_q != acc_q) begin
              cand_q  <= sync_q;
              cnt_q   <= CntOne;
              state_q <= StValidando;
            end else begin
              cnt_q <= '0;
            end
          end
          StValidando: begin
            if (sync_q == acc_q) begin
              // Input went back to the accepted code: treat as a glitch.
              cnt_q   <= '0;
              state_q <= StEstable;
            end else if (sync_q != cand_q) begin
              // A different new code: restart validation on it.
              cand_q <= sync_q;
              cnt_q  <= CntOne;
            end else if (cnt_inc == CntAccept) begin
              acc_q        <= cand_q;
              codigo_bin_o <= gray2bin(cand_q);
              cambio_o     <= 1'b1;
              cnt_q        <= '0;
              state_q      <= StEstable;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= StEstable;
          end
        endcase
      end
    end
  end

endmodule
